instr_fetch_unit: RTL and testbench

- Instruction producer for the 8-bit CPU's control-unit decoder. Keeps the PC, fetches one 8-bit instruction at a time from program memory over a request/response interface, and presents it on a valid/ready handshake.
- Accepts jump redirects from the control path.
- Sits between program memory and the decode/control stage.

---
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch for the 8-bit CPU: PC, one-at-a-time imem read, valid/ready issue to decode; 2 cycles req-to-issue with 1-cycle memory.
// Holds the instruction while instr_ready is low; halt only gates new requests. Optional macro IFU_ILLEGAL_SKIP_EN skips opcode 3'b111.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               illegal_op
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_imem_req;
  logic [ADDR_W-1:0]  r_imem_addr;
  logic [INSTR_W-1:0] r_instr_out;
  logic                r_instr_valid;
  logic                r_illegal_op;

  logic [ADDR_W-1:0]   w_pc_inc;
  logic                w_illegal;

  assign w_pc_inc = r_pc + ADDR_W'(1);

`ifdef IFU_ILLEGAL_SKIP_EN
  assign w_illegal = imem_valid && (imem_rdata[2:0] == 3'b111);
`else
  assign w_illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= '0;
      r_instr_out   <= '0;
      r_instr_valid <= 1'b0;
      r_illegal_op  <= 1'b0;
    end else begin
      r_imem_req <= 1'b0;
      case (r_state)
        S_REQ: begin
          // A jump here must not launch a request to the stale PC.
          if (jump) begin
            r_pc <= jump_addr;
          end else if (!halt) begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_pc;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (jump) begin
            r_pc          <= jump_addr;
            r_instr_valid <= 1'b0;
            r_state       <= imem_valid ? S_REQ : S_DRAIN;
            if (w_illegal) r_illegal_op <= 1'b1;
          end else if (imem_valid) begin
            if (w_illegal) begin
              r_illegal_op <= 1'b1;
              r_pc         <= w_pc_inc;
              r_state      <= S_REQ;
            end else begin
              r_instr_out   <= imem_rdata;
              r_instr_valid <= 1'b1;
              r_state       <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (jump) begin
            r_pc          <= jump_addr;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
          end else if (instr_ready) begin
            r_pc          <= w_pc_inc;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
          end
        end
        S_DRAIN: begin
          // The response to the abandoned request is swallowed here.
          if (jump) r_pc <= jump_addr;
          if (imem_valid) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr_out   = r_instr_out;
  assign instr_valid = r_instr_valid;
  assign pc_out      = r_pc;
  assign illegal_op  = r_illegal_op;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level model of PC / outstanding request / held instruction checked every cycle,
// a latency-programmable memory, and directed scenarios with literal expectations.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid;
  logic [7:0] imem_rdata;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic       instr_ready;
  logic       jump;
  logic [7:0] jump_addr;
  logic       halt;
  logic [7:0] pc_out;
  logic       illegal_op;

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jump(jump), .jump_addr(jump_addr), .halt(halt),
    .pc_out(pc_out), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [256];
  int         lat;
  logic       pend;
  logic [7:0] pend_addr;
  int         pend_cnt;

  // Abstract view: PC, whether a request is in flight and whether its answer is to be dropped,
  // whether an instruction is being offered, and what the outputs must show next cycle.
  logic [7:0] m_pc, m_addr, m_instr;
  logic       m_out, m_disc, m_have, m_req, m_ill, m_rst;
  logic       m_resp, m_bad;

  logic [7:0] req_q[$];
  logic [7:0] acc_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && imem_req !== 1'b1; i++) step();
    chk("wait_req", imem_req, 1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && instr_valid !== 1'b1; i++) step();
    chk("wait_valid", instr_valid, 1);
  endtask

  // Per-cycle compare, memory and model update, all at the falling edge.
  initial begin
    m_pc = 8'h00; m_addr = 8'h00; m_instr = 8'h00;
    m_out = 0; m_disc = 0; m_have = 0; m_req = 0; m_ill = 0; m_rst = 1;
    pend = 0; pend_addr = 0; pend_cnt = 0;
    imem_valid = 0; imem_rdata = 8'hEE;
    forever begin
      @(negedge clk);
      chk("imem_req", imem_req, m_req);
      if (m_req || m_rst) chk("imem_addr", imem_addr, m_addr);
      chk("instr_valid", instr_valid, m_have);
      if (m_have || m_rst) chk("instr_out", instr_out, m_instr);
      chk("pc_out", pc_out, m_pc);
      chk("illegal_op", illegal_op, m_ill);

      if (rst_n === 1'b1 && imem_req === 1'b1) req_q.push_back(imem_addr);
      if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready && !jump) acc_q.push_back(instr_out);

      // Memory is reset along with the fetch unit, so a pre-reset request never answers.
      if (!rst_n) begin
        pend = 0; imem_valid = 0; imem_rdata = 8'hEE;
      end else begin
        imem_valid = 0; imem_rdata = 8'hEE;
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            imem_valid = 1; imem_rdata = mem[pend_addr]; pend = 0;
          end
        end
        if (imem_req === 1'b1) begin
          pend = 1; pend_addr = imem_addr; pend_cnt = lat;
        end
      end

      if (!rst_n) begin
        m_pc = 8'h00; m_out = 0; m_disc = 0; m_have = 0; m_instr = 8'h00;
        m_req = 0; m_addr = 8'h00; m_ill = 0; m_rst = 1;
      end else begin
        m_rst = 0; m_req = 0;
        m_resp = m_out && imem_valid;
`ifdef IFU_ILLEGAL_SKIP_EN
        m_bad = m_resp && !m_disc && (imem_rdata[2:0] == 3'b111);
`else
        m_bad = 0;
`endif
        if (jump) begin
          m_pc = jump_addr; m_have = 0;
          if (m_bad) m_ill = 1;
          if (m_out && !m_resp) m_disc = 1;
          else begin m_out = 0; m_disc = 0; end
        end else if (m_out) begin
          if (m_resp) begin
            m_out = 0;
            if (m_disc) m_disc = 0;
            else if (m_bad) begin m_ill = 1; m_pc = m_pc + 8'd1; end
            else begin m_have = 1; m_instr = imem_rdata; end
          end
        end else if (m_have) begin
          if (instr_ready) begin m_have = 0; m_pc = m_pc + 8'd1; end
        end else if (!halt) begin
          m_req = 1; m_addr = m_pc; m_out = 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 2);
    rst_n = 0; instr_ready = 0; jump = 0; jump_addr = 8'h00; halt = 0; lat = 1;
    step(); step();
    rst_n = 1;

    // Straight-line fetch of 0x02,0x03,0x04 with a 1-cycle memory.
    instr_ready = 1;
    for (int i = 0; i < 40 && acc_q.size() < 3; i++) step();
    chk("t1_pc_end", pc_out, 8'h03);
    instr_ready = 0;
    chk("t1_addr0", req_q[0], 8'h00);
    chk("t1_addr1", req_q[1], 8'h01);
    chk("t1_addr2", req_q[2], 8'h02);
    chk("t1_ins0", acc_q[0], 8'h02);
    chk("t1_ins1", acc_q[1], 8'h03);
    chk("t1_ins2", acc_q[2], 8'h04);

    // Backpressure: hold the instruction for 5 cycles.
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", instr_valid, 1);
      chk("t2_instr", instr_out, 8'h05);
      chk("t2_noreq", imem_req, 0);
      chk("t2_pc", pc_out, 8'h03);
      step();
    end
    lat = 3;
    instr_ready = 1; step(); instr_ready = 0;
    wait_req(20);
    chk("t2_next_addr", imem_addr, 8'h04);

    // Jump while waiting on a slow memory: stale 0x06 must be dropped.
    jump = 1; jump_addr = 8'h40; step(); jump = 0;
    chk("t3_pc", pc_out, 8'h40);
    wait_req(20);
    chk("t3_addr", imem_addr, 8'h40);
    wait_valid(20);
    chk("t3_instr", instr_out, 8'h42);

    // Jump and ready together in ISSUE: jump target wins over pc+1.
    jump = 1; jump_addr = 8'h10; step(); jump = 0;
    wait_valid(20);
    chk("t4_pc", pc_out, 8'h10);
    chk("t4_instr", instr_out, 8'h12);
    jump = 1; jump_addr = 8'h80; instr_ready = 1; step(); jump = 0; instr_ready = 0;
    wait_req(20);
    chk("t4_addr", imem_addr, 8'h80);

    // PC wrap from 0xFF.
    wait_valid(20);
    jump = 1; jump_addr = 8'hFF; step(); jump = 0;
    wait_valid(20);
    chk("t5_instr", instr_out, 8'h01);
    chk("t5_pc", pc_out, 8'hFF);
    instr_ready = 1; step(); instr_ready = 0;
    chk("t5_pc_wrap", pc_out, 8'h00);
    wait_req(20);
    chk("t5_addr", imem_addr, 8'h00);

    // Reset in the middle of a wait.
    wait_valid(20);
    jump = 1; jump_addr = 8'h30; step(); jump = 0;
    wait_req(20);
    rst_n = 0; step(); rst_n = 1;
    chk("t6_pc", pc_out, 8'h00);
    chk("t6_valid", instr_valid, 0);
    chk("t6_req", imem_req, 0);
    wait_req(20);
    chk("t6_addr", imem_addr, 8'h00);
    wait_valid(20);
    chk("t6_instr", instr_out, 8'h02);

    // halt blocks only new requests, not a wait already in progress.
    halt = 1; instr_ready = 1; step(); instr_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t7_halted", imem_req, 0);
      chk("t7_pc", pc_out, 8'h01);
      step();
    end
    halt = 0;
    wait_req(20);
    chk("t7_addr", imem_addr, 8'h01);
    halt = 1;
    wait_valid(20);
    chk("t7_instr", instr_out, 8'h03);
    halt = 0;

    // Opcode 3'b111 at address 5.
    lat = 1;
    jump = 1; jump_addr = 8'h05; step(); jump = 0;
`ifdef IFU_ILLEGAL_SKIP_EN
    instr_ready = 1;
    wait_req(20);
    chk("t8_addr5", imem_addr, 8'h05);
    step();
    wait_req(20);
    chk("t8_addr6", imem_addr, 8'h06);
    chk("t8_pc", pc_out, 8'h06);
    chk("t8_ill", illegal_op, 1);
    repeat (4) step();
    chk("t8_ill_sticky", illegal_op, 1);
    instr_ready = 0;
`else
    wait_req(20);
    chk("t8_addr5", imem_addr, 8'h05);
    wait_valid(20);
    chk("t8_instr", instr_out, 8'h07);
    chk("t8_ill", illegal_op, 0);
`endif
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
